// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit text driver: FSM encodings,
// command bytes and character/table lookup helpers.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_CFG,
    ST_IDLE,
    ST_ADDR1,
    ST_LINE1,
    ST_ADDR2,
    ST_LINE2
  } lcd_state_t;

  typedef enum logic [2:0] {
    NW_IDLE,
    NW_SETUP,
    NW_HIGH,
    NW_HOLD,
    NW_POST
  } nw_phase_t;

  localparam logic [7:0] CMD_FUNC_SET = 8'h28;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  localparam logic [3:0] INIT_NIB_8BIT = 4'h3;
  localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

  // Char k lives at [255-8k -: 8]; its LSB is at 8*(31-k) = {~k, 3'b000}.
  function automatic logic [7:0] char_at(input logic [255:0] s, input logic [4:0] k);
    return s[{~k, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_ENTRY;
      default: return CMD_CLEAR;
    endcase
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// Emits one LCD nibble: setup, enable pulse and hold of T_E cycles each,
// then a caller-chosen post-delay; done pulses once the delay has elapsed.
module lcd_nibble_writer
  import lcd_pkg::*;
#(
  parameter int unsigned T_E = 12,
  parameter int unsigned DW  = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          rs,
  input  logic [3:0]    nib,
  input  logic [DW-1:0] post_delay,
  output logic          lcde,
  output logic          lcdrs,
  output logic [3:0]    lcddat,
  output logic          done
);

  nw_phase_t     phase, phase_nxt;
  logic [DW-1:0] cnt;
  logic [DW-1:0] post_q;
  logic          phase_end;

  always_comb begin
    phase_end = 1'b0;
    phase_nxt = phase;
    case (phase)
      NW_SETUP, NW_HIGH, NW_HOLD: phase_end = (cnt == DW'(T_E - 1));
      NW_POST:                    phase_end = (({1'b0, cnt} + 1'b1) >= {1'b0, post_q});
      default:                    phase_end = 1'b0;
    endcase
    case (phase)
      NW_IDLE:  if (start)     phase_nxt = NW_SETUP;
      NW_SETUP: if (phase_end) phase_nxt = NW_HIGH;
      NW_HIGH:  if (phase_end) phase_nxt = NW_HOLD;
      NW_HOLD:  if (phase_end) phase_nxt = NW_POST;
      NW_POST:  if (phase_end) phase_nxt = NW_IDLE;
      default:                 phase_nxt = NW_IDLE;
    endcase
  end

  // RS/DAT are latched only on start, so they stay put through hold and post-delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase  <= NW_IDLE;
      cnt    <= '0;
      post_q <= '0;
      lcde   <= 1'b0;
      lcdrs  <= 1'b0;
      lcddat <= '0;
      done   <= 1'b0;
    end else begin
      phase <= phase_nxt;
      done  <= (phase == NW_POST) && phase_end;
      lcde  <= (phase_nxt == NW_HIGH);
      cnt   <= ((phase_nxt != phase) || (phase == NW_IDLE)) ? '0 : cnt + DW'(1);
      if ((phase == NW_IDLE) && start) begin
        lcdrs  <= rs;
        lcddat <= nib;
        post_q <= post_delay;
      end
    end
  end

endmodule

// File: rtl/lcd_text_driver.sv
// HD44780 4-bit write-only driver: power-on init, then refreshes both
// 16-char lines from a snapshot of strdata on each cls request.
module lcd_text_driver
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWRUP = 750000,
  parameter int unsigned T_INIT1 = 205000,
  parameter int unsigned T_INIT2 = 5000,
  parameter int unsigned T_CMD   = 2000,
  parameter int unsigned T_CLR   = 82000,
  parameter int unsigned T_E     = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cls,
  input  logic [255:0] strdata,
  output logic         busy,
  output logic         LCDE,
  output logic         LCDRS,
  output logic         LCDRW,
  output logic [3:0]   LCDDAT
);

  localparam int unsigned T_MAX = max2(max2(max2(T_PWRUP, T_INIT1), max2(T_INIT2, T_CMD)),
                                       max2(T_CLR, T_E));
  localparam int unsigned DW    = (T_MAX > 1) ? $clog2(T_MAX + 1) : 1;

  lcd_state_t    state, state_nxt;
  logic [DW-1:0] dly_cnt;
  logic [1:0]    step;
  logic          half;
  logic [4:0]    chr_cnt;
  logic [255:0]  snap;
  logic          pending;
  logic          issued;

  logic          nw_start, nw_rs, nw_done;
  logic [3:0]    nw_nib;
  logic [DW-1:0] nw_post;
  logic [7:0]    cur_byte;
  logic          unit_done;
  logic          writing;
  logic          refresh_go;

  assign writing  = (state != ST_PWRUP) && (state != ST_IDLE);
  assign nw_start = writing && !issued;
  assign busy     = (state != ST_IDLE);
  assign LCDRW    = 1'b0;

  always_comb begin
    cur_byte  = '0;
    nw_rs     = 1'b0;
    nw_nib    = '0;
    nw_post   = DW'(T_E);
    unit_done = nw_done && ((state == ST_INIT) || half);
    state_nxt = state;

    case (state)
      ST_CFG:             cur_byte = cfg_byte(step);
      ST_ADDR1:           cur_byte = CMD_LINE1;
      ST_ADDR2:           cur_byte = CMD_LINE2;
      ST_LINE1, ST_LINE2: begin
        cur_byte = char_at(snap, chr_cnt);
        nw_rs    = 1'b1;
      end
      default:            cur_byte = '0;
    endcase

    // INIT sends lone nibbles; every other writing state sends high/low pairs.
    if (state == ST_INIT) begin
      nw_nib = (step == 2'd3) ? INIT_NIB_4BIT : INIT_NIB_8BIT;
      case (step)
        2'd0:    nw_post = DW'(T_INIT1);
        2'd3:    nw_post = DW'(T_CMD);
        default: nw_post = DW'(T_INIT2);
      endcase
    end else begin
      nw_nib = half ? cur_byte[3:0] : cur_byte[7:4];
      if (half)
        nw_post = ((state == ST_CFG) && (step == 2'd3)) ? DW'(T_CLR) : DW'(T_CMD);
    end

    case (state)
      ST_PWRUP: if (dly_cnt == DW'(T_PWRUP - 1))            state_nxt = ST_INIT;
      ST_INIT:  if (unit_done && (step == 2'd3))            state_nxt = ST_CFG;
      ST_CFG:   if (unit_done && (step == 2'd3))            state_nxt = ST_ADDR1;
      ST_IDLE:  if (cls || pending)                         state_nxt = ST_ADDR1;
      ST_ADDR1: if (unit_done)                              state_nxt = ST_LINE1;
      ST_LINE1: if (unit_done && (chr_cnt == 5'd15))        state_nxt = ST_ADDR2;
      ST_ADDR2: if (unit_done)                              state_nxt = ST_LINE2;
      ST_LINE2: if (unit_done && (chr_cnt == 5'd31))        state_nxt = ST_IDLE;
      default:                                              state_nxt = ST_PWRUP;
    endcase
  end

  assign refresh_go = (state_nxt == ST_ADDR1) && (state != ST_ADDR1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_PWRUP;
      dly_cnt <= '0;
      step    <= '0;
      half    <= 1'b0;
      chr_cnt <= '0;
      snap    <= '0;
      pending <= 1'b0;
      issued  <= 1'b0;
    end else begin
      state   <= state_nxt;
      dly_cnt <= (state == ST_PWRUP) ? dly_cnt + DW'(1) : '0;

      if (nw_start)     issued <= 1'b1;
      else if (nw_done) issued <= 1'b0;

      if (nw_done && (state != ST_INIT)) half <= ~half;

      if (state_nxt != state) step <= '0;
      else if (unit_done)     step <= step + 2'd1;

      // LINE1 ends at 15, so the increment carries the counter straight to 16.
      if (refresh_go)
        chr_cnt <= '0;
      else if (unit_done && ((state == ST_LINE1) ||
                             ((state == ST_LINE2) && (chr_cnt != 5'd31))))
        chr_cnt <= chr_cnt + 5'd1;

      if (refresh_go) snap <= strdata;

      if ((state == ST_IDLE) && refresh_go) pending <= 1'b0;
      else if (cls && (state != ST_IDLE))   pending <= 1'b1;
    end
  end

  lcd_nibble_writer #(
    .T_E (T_E),
    .DW  (DW)
  ) u_nibble (
    .clk        (clk),
    .rst        (rst),
    .start      (nw_start),
    .rs         (nw_rs),
    .nib        (nw_nib),
    .post_delay (nw_post),
    .lcde       (LCDE),
    .lcdrs      (LCDRS),
    .lcddat     (LCDDAT),
    .done       (nw_done)
  );

endmodule
